// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter for the ALU and load writeback paths, plus a pending-write scoreboard.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin ties; the default build gives requester 1 fixed priority.
module rf_write_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            reserve_valid,
  input  logic [4:0]      reserve_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_rd_din,
  output logic            rf_write_enable,
  output logic [NREG-1:0] pending
);

  logic            grant0;
  logic            grant1;
  logic            accept0;
  logic            accept1;
  logic            accept;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] one_hot;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clear_vec;

`ifdef RF_ARB_ROUND_ROBIN_EN
  typedef enum logic [1:0] {IDLE, GRANTED0, GRANTED1} state_t;

  state_t state;
  logic   last_q;
  logic   last;

  // The state names who won last cycle; after an idle cycle the stored pointer is used instead.
  always_comb begin
    last = last_q;
    case (state)
      GRANTED0: last = 1'b0;
      GRANTED1: last = 1'b1;
      default:  last = last_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_q <= 1'b1;
    end else if (accept) begin
      state  <= accept1 ? GRANTED1 : GRANTED0;
      last_q <= accept1;
    end else begin
      state  <= IDLE;
    end
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        grant0 = last;
        grant1 = !last;
`else
        grant1 = 1'b1;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept0    = req0_valid && grant0;
  assign accept1    = req1_valid && grant1;
  assign accept     = accept0 || accept1;
  assign win_rd     = accept1 ? req1_rd : req0_rd;
  assign win_data   = accept1 ? req1_data : req0_data;

  // x0 never enters the scoreboard, so neither vector can touch bit 0.
  assign one_hot   = {{(NREG-1){1'b0}}, 1'b1};
  assign set_vec   = (reserve_valid && reserve_rd != 5'd0) ? (one_hot << reserve_rd) : '0;
  assign clear_vec = (accept && win_rd != 5'd0) ? (one_hot << win_rd) : '0;

  assign hazard = !reset &&
                  ((chk_rs1 != 5'd0 && pending[chk_rs1]) ||
                   (chk_rs2 != 5'd0 && pending[chk_rs2]));

  // Set is applied after clear so a fresh reservation survives a same-edge writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_rd           <= 5'd0;
      rf_rd_din       <= '0;
      pending         <= '0;
    end else begin
      rf_write_enable <= accept && (win_rd != 5'd0);
      if (accept) begin
        rf_rd     <= win_rd;
        rf_rd_din <= win_data;
      end
      pending <= (pending & ~clear_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, reset/contention sequences,
// then randomized traffic against a scoreboard-array reference model.
module tb_rf_write_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req1_valid;
  logic [4:0]      req0_rd, req1_rd;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready;
  logic            reserve_valid;
  logic [4:0]      reserve_rd;
  logic [4:0]      chk_rs1, chk_rs2;
  logic            hazard;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_rd_din;
  logic            rf_write_enable;
  logic [NREG-1:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r0v;
    logic [4:0]  r0rd;
    logic [31:0] r0d;
    logic        r1v;
    logic [4:0]  r1rd;
    logic [31:0] r1d;
    logic        resv;
    logic [4:0]  resrd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_r0rdy;
    logic        e_r1rdy;
    logic        e_hz;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_din;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[12];

  // Reference model state: one flag per architectural register plus the tie pointer.
  bit          pend_m[NREG];
  int          last_m;
  bit          we_m;
  logic [4:0]  rd_m;
  logic [31:0] din_m;

  always #5 clk = ~clk;

  rf_write_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .rf_rd(rf_rd), .rf_rd_din(rf_rd_din), .rf_write_enable(rf_write_enable),
    .pending(pending)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid    = v.r0v;
    req0_rd       = v.r0rd;
    req0_data     = v.r0d;
    req1_valid    = v.r1v;
    req1_rd       = v.r1rd;
    req1_data     = v.r1d;
    reserve_valid = v.resv;
    reserve_rd    = v.resrd;
    chk_rs1       = v.rs1;
    chk_rs2       = v.rs2;
  endtask

  task automatic idleInputs();
    req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
    reserve_valid = 1'b0; reserve_rd = 5'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
  endtask

  function automatic int pickWinner(bit v0, bit v1);
    if (v0 && v1) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      return (last_m == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] packPending();
    logic [31:0] pv;
    pv = 32'd0;
    for (int i = 0; i < NREG; i++) pv[i] = pend_m[i];
    return pv;
  endfunction

  initial begin
    int          win;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        exp_hz;
    int          exp_grant;

    //           r0v r0rd   r0d           r1v r1rd   r1d     resv resrd  rs1    rs2    rdy0 rdy1 hz   we   rd     din           pend
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd9,  5'd0,  5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h200};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        32'h200};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 5'd0,  5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h11,       32'h0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h7, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1000};
    tbl[8]  = '{1'b1, 5'd12, 32'hABC,     1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'hABC,      32'h1000};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd0,  5'd12, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        32'h1000};
    tbl[10] = '{1'b1, 5'd12, 32'h55,      1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h55,       32'h400};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        32'h400};

    idleInputs();
    reset = 1'b1;
    #1;
    checkOutput("reset_we", 32'(rf_write_enable), 32'd0);
    checkOutput("reset_pending", pending, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      #3;
      checkOutput($sformatf("tbl%0d_ready0", i), 32'(req0_ready && req0_valid), 32'(tbl[i].e_r0rdy));
      checkOutput($sformatf("tbl%0d_ready1", i), 32'(req1_ready && req1_valid), 32'(tbl[i].e_r1rdy));
      checkOutput($sformatf("tbl%0d_hazard", i), 32'(hazard), 32'(tbl[i].e_hz));
      @(posedge clk); #1;
      checkOutput($sformatf("tbl%0d_we", i), 32'(rf_write_enable), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        checkOutput($sformatf("tbl%0d_rd", i), 32'(rf_rd), 32'(tbl[i].e_rd));
        checkOutput($sformatf("tbl%0d_din", i), rf_rd_din, tbl[i].e_din);
      end
      checkOutput($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
    end

    // Mid-run reset with pending[10] set and a held nonzero rf_rd/rf_rd_din.
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h100;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h200;
    reserve_valid = 1'b0; chk_rs1 = 5'd10; chk_rs2 = 5'd0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_we", 32'(rf_write_enable), 32'd0);
    checkOutput("rst_rd", 32'(rf_rd), 32'd0);
    checkOutput("rst_din", rf_rd_din, 32'd0);
    checkOutput("rst_pending", pending, 32'd0);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rst_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Four cycles of contention starting with the first tie after reset.
    for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      exp_grant = (k % 2 == 0) ? 0 : 1;
`else
      exp_grant = 1;
`endif
      checkOutput($sformatf("tie%0d_ready0", k), 32'(req0_ready), 32'(exp_grant == 0));
      checkOutput($sformatf("tie%0d_ready1", k), 32'(req1_ready), 32'(exp_grant == 1));
      @(posedge clk); #1;
      checkOutput($sformatf("tie%0d_we", k), 32'(rf_write_enable), 32'd1);
      checkOutput($sformatf("tie%0d_rd", k), 32'(rf_rd), (exp_grant == 0) ? 32'd3 : 32'd4);
      checkOutput($sformatf("tie%0d_din", k), rf_rd_din, (exp_grant == 0) ? 32'h100 : 32'h200);
    end
    idleInputs();
    @(posedge clk); #1;
    checkOutput("tie_after_we", 32'(rf_write_enable), 32'd0);

    // Randomized traffic against the reference model, starting from a fresh reset.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) pend_m[i] = 1'b0;
    last_m = 1;
    for (int c = 0; c < 400; c++) begin
      req0_valid    = 1'($urandom_range(0, 1));
      req0_rd       = 5'($urandom_range(0, 15));
      req0_data     = $urandom;
      req1_valid    = 1'($urandom_range(0, 1));
      req1_rd       = 5'($urandom_range(0, 15));
      req1_data     = $urandom;
      reserve_valid = 1'($urandom_range(0, 1));
      reserve_rd    = 5'($urandom_range(0, 15));
      chk_rs1       = 5'($urandom_range(0, 15));
      chk_rs2       = 5'($urandom_range(0, 15));
      #3;
      win = pickWinner(req0_valid, req1_valid);
      exp_hz = (chk_rs1 != 5'd0 && pend_m[chk_rs1]) || (chk_rs2 != 5'd0 && pend_m[chk_rs2]);
      checkOutput("rnd_ready0", 32'(req0_ready && req0_valid), 32'(win == 0));
      checkOutput("rnd_ready1", 32'(req1_ready && req1_valid), 32'(win == 1));
      checkOutput("rnd_one_ready", 32'(req0_ready && req1_ready), 32'd0);
      checkOutput("rnd_hazard", 32'(hazard), 32'(exp_hz));
      if (win >= 0) begin
        wrd   = (win == 1) ? req1_rd : req0_rd;
        wdata = (win == 1) ? req1_data : req0_data;
        rd_m  = wrd;
        din_m = wdata;
        we_m  = (wrd != 5'd0);
        if (we_m) pend_m[wrd] = 1'b0;
        last_m = win;
      end else begin
        we_m = 1'b0;
      end
      if (reserve_valid && reserve_rd != 5'd0) pend_m[reserve_rd] = 1'b1;
      @(posedge clk); #1;
      checkOutput("rnd_we", 32'(rf_write_enable), 32'(we_m));
      if (we_m) begin
        checkOutput("rnd_rd", 32'(rf_rd), 32'(rd_m));
        checkOutput("rnd_din", rf_rd_din, din_m);
      end
      checkOutput("rnd_pending", pending, packPending());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
